keypad_scanner: RTL and testbench

- Input-side counterpart of the 4-digit seven-segment display driver.
- Scans a 4x4 hex matrix keypad by driving one row low at a time, using the same rotating active-low pattern as the display anodes, and reads the column lines.
- Debounces each press and emits a one-cycle key strobe with a 4-bit hex code.
- Maintains a 4-digit shift register whose digit outputs feed the display driver's dgt1..dgt4 inputs directly.

---
 rtl/kpd_pkg.sv | 38 +++
 rtl/kpd_sync2.sv | 29 ++
 rtl/keypad_scanner.sv | 179 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kpd_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding, the rotating
// active-low row pattern (same sequence as the display anode drive) and the
// 4x4 hex key map indexed by {row, column}.
package kpd_pkg;

  typedef enum logic [1:0] {
    StScan     = 2'd0,
    StDebounce = 2'd1,
    StPressed  = 2'd2
  } state_e;

  // Index 0..3 = row 0..3; the driven row is the zero bit.
  localparam logic [3:0] ROW_PATTERN [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Entry {row, col}; column 0 is col_in[3].
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // Lowest-index low column; column 0 lives in bit 3.
  function automatic logic [1:0] first_low_col(input logic [3:0] cols);
    logic [1:0] idx;
    if (!cols[3]) begin
      idx = 2'd0;
    end else if (!cols[2]) begin
      idx = 2'd1;
    end else if (!cols[1]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/kpd_sync2.sv
// Two-flop synchroniser for the 4 keypad column lines.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset (flops go to 1111, i.e. no key)
//   d_i    - asynchronous column inputs
//   q_o    - synchronised columns
module kpd_sync2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with debounce, key strobe and a 4-digit history
// register that feeds a seven-segment display driver directly.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset
//   col_in     - active-low column lines, col_in[3] = column 0
//   clear      - zeroes the digit history
//   row_out    - active-low one-hot row drive
//   key_valid  - one-cycle strobe on an accepted press
//   key_code   - hex code of the last accepted key
//   key_held   - high while the accepted key stays pressed
//   dgt1..dgt4 - digit history, dgt1 newest
module keypad_scanner
  import kpd_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  input  logic       clear,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [3:0] dgt1,
  output logic [3:0] dgt2,
  output logic [3:0] dgt3,
  output logic [3:0] dgt4
);

  // One counter serves the dwell, press-debounce and release-debounce phases.
  localparam int unsigned CntMax = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CNT - 1);

  logic [3:0] cols;

  kpd_sync2 u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (col_in),
    .q_o   (cols)
  );

  state_e          state_q, state_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic [3:0]      pat_q, pat_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;
  logic [3:0]      dgt1_q, dgt1_d, dgt2_q, dgt2_d, dgt3_q, dgt3_d, dgt4_q, dgt4_d;
  logic            accept;
  logic [3:0]      new_code;

  assign new_code = KEY_MAP[{row_q, col_q}];

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;

    case (state_q)
      StScan: begin
        if (cnt_q == ScanLast) begin
          cnt_d = '0;
          if (&cols) begin
            row_d = row_q + 2'd1;
          end else begin
            pat_d   = cols;
            col_d   = first_low_col(cols);
            state_d = StDebounce;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDebounce: begin
        if (cols == pat_q) begin
          if (cnt_q == DebLast) begin
            accept  = 1'b1;
            cnt_d   = '0;
            state_d = StPressed;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          row_d   = row_q + 2'd1;
          state_d = StScan;
        end
      end
      StPressed: begin
        if (&cols) begin
          if (cnt_q == DebLast) begin
            cnt_d   = '0;
            row_d   = row_q + 2'd1;
            state_d = StScan;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StScan;
      end
    endcase
  end

  // Strobe, code and digit history; a same-cycle clear still keeps the new key.
  always_comb begin
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    dgt1_d      = dgt1_q;
    dgt2_d      = dgt2_q;
    dgt3_d      = dgt3_q;
    dgt4_d      = dgt4_q;
    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = new_code;
      dgt1_d      = new_code;
      dgt2_d      = clear ? 4'h0 : dgt1_q;
      dgt3_d      = clear ? 4'h0 : dgt2_q;
      dgt4_d      = clear ? 4'h0 : dgt3_q;
    end else if (clear) begin
      dgt1_d = 4'h0;
      dgt2_d = 4'h0;
      dgt3_d = 4'h0;
      dgt4_d = 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StScan;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      pat_q       <= 4'hF;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      dgt1_q      <= 4'h0;
      dgt2_q      <= 4'h0;
      dgt3_q      <= 4'h0;
      dgt4_q      <= 4'h0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      dgt1_q      <= dgt1_d;
      dgt2_q      <= dgt2_d;
      dgt3_q      <= dgt3_d;
      dgt4_q      <= dgt4_d;
    end
  end

  assign row_out   = ROW_PATTERN[row_q];
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = (state_q == StPressed);
  assign dgt1      = dgt1_q;
  assign dgt2      = dgt2_q;
  assign dgt3      = dgt3_q;
  assign dgt4      = dgt4_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8.
// A keypad model pulls a column low whenever a pressed key's row is driven.
module tb_keypad_scanner;

  localparam logic [3:0] ROW_PAT [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [3:0] dgt1, dgt2, dgt3, dgt4;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_in    (col_in),
    .clear     (clear),
    .row_out   (row_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .dgt1      (dgt1),
    .dgt2      (dgt2),
    .dgt3      (dgt3),
    .dgt4      (dgt4)
  );

  always #5 clk = ~clk;

  // Pressed keys per row; bit 3 = column 0, matching col_in.
  logic [3:0] krow [4];

  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (row_out == ROW_PAT[r]) col_in = col_in & ~krow[r];
    end
  end

  int total  = 0;
  int bad    = 0;
  int vcount = 0;

  always @(negedge clk) if (key_valid) vcount++;

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
    int         hold;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_key(input int r, input int c);
    krow[r] = krow[r] | (4'b1000 >> c);
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) krow[r] = 4'h0;
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (1) begin
      tick();
      n++;
      if (key_valid) return;
      if (n >= bound) begin
        n = -1;
        return;
      end
    end
  endtask

  // Returns at the first negedge after row r becomes driven.
  task automatic wait_row_entry(input int r, output bit ok);
    logic [3:0] prev;
    ok   = 1'b0;
    prev = row_out;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (row_out == ROW_PAT[r] && prev != ROW_PAT[r]) begin
        ok = 1'b1;
        return;
      end
      prev = row_out;
    end
  endtask

  task automatic wait_release(output int m);
    m = 0;
    while (key_held && m < 40) begin
      tick();
      m++;
    end
  endtask

  task automatic press_release(input int r, input int c, input logic [3:0] exp, input int hold);
    int n, m, base;
    base = vcount;
    set_key(r, c);
    wait_valid(64, n);
    check("strobe_seen", (n >= 0) ? 32'd1 : 32'd0, 32'd1);
    check("key_code", key_code, exp);
    check("dgt1_new", dgt1, exp);
    tick();
    check("strobe_width", key_valid, 1'b0);
    check("held_after", key_held, 1'b1);
    repeat (hold) tick();
    check("held_long", key_held, 1'b1);
    release_all();
    wait_release(m);
    check("release_lat", m, 32'd10);
    repeat (4) tick();
    check("one_pulse", vcount - base, 32'd1);
  endtask

  initial begin
    int  n, m, base;
    bit  ok;

    vecs[0] = '{1, 2, 4'h6, 30};
    vecs[1] = '{0, 0, 4'h1, 3};
    vecs[2] = '{0, 1, 4'h2, 3};
    vecs[3] = '{0, 2, 4'h3, 3};
    vecs[4] = '{0, 3, 4'hA, 3};
    vecs[5] = '{1, 1, 4'h5, 3};

    release_all();
    repeat (3) tick();
    check("rst_row", row_out, 4'b0111);
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 4'h0);
    check("rst_held", key_held, 1'b0);
    check("rst_dgts", {dgt4, dgt3, dgt2, dgt1}, 16'h0000);

    // Idle rotation: a new row every 4 clocks.
    reset = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      check("idle_row", row_out, ROW_PAT[(i / 4) % 4]);
      tick();
    end
    check("idle_no_strobe", vcount, 32'd0);
    check("idle_dgts", {dgt4, dgt3, dgt2, dgt1}, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      press_release(vecs[i].r, vecs[i].c, vecs[i].code, vecs[i].hold);
    end
    check("hist_dgts", {dgt4, dgt3, dgt2, dgt1}, 16'h23A5);
    check("pulse_total", vcount, 32'd6);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_dgts", {dgt4, dgt3, dgt2, dgt1}, 16'h0000);

    // Two keys in row 3, lowest column wins; clear lands in the strobe cycle.
    press_release(1, 0, 4'h4, 2);
    press_release(1, 1, 4'h5, 2);
    check("pre_clr_dgts", {dgt4, dgt3, dgt2, dgt1}, 16'h0045);
    wait_row_entry(3, ok);
    check("align_r3", ok, 1'b1);
    set_key(3, 1);
    set_key(3, 3);
    repeat (11) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("f_strobe", key_valid, 1'b1);
    check("f_code", key_code, 4'hF);
    check("f_clr_dgts", {dgt4, dgt3, dgt2, dgt1}, 16'h000F);
    release_all();
    tick();
    wait_release(m);
    check("f_released", key_held, 1'b0);
    repeat (4) tick();

    // Bounce: low 3, high 1, low 3 on row 1.
    wait_row_entry(1, ok);
    check("align_r1", ok, 1'b1);
    base = vcount;
    set_key(1, 0);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 3 || i == 7) release_all();
      if (i == 4) set_key(1, 0);
      if (i == 4 || i == 5) check("bnc_row_hold", row_out, 4'b1011);
      if (i == 6) check("bnc_row_r2", row_out, 4'b1101);
      if (i == 10) check("bnc_row_r3", row_out, 4'b1110);
      if (i == 14) check("bnc_row_r0", row_out, 4'b0111);
    end
    check("bnc_no_strobe", vcount - base, 32'd0);
    check("bnc_not_held", key_held, 1'b0);
    check("bnc_dgts", {dgt4, dgt3, dgt2, dgt1}, 16'h000F);

    // Reset while PRESSED, key kept down: fresh strobe after full latency.
    set_key(0, 1);
    wait_valid(64, n);
    check("pr_strobe_seen", (n >= 0) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) tick();
    check("pr_held", key_held, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("pr_rst_held", key_held, 1'b0);
    check("pr_rst_row", row_out, 4'b0111);
    check("pr_rst_dgts", {dgt4, dgt3, dgt2, dgt1}, 16'h0000);
    check("pr_rst_code", key_code, 4'h0);
    wait_valid(64, n);
    check("pr_latency", n, 32'd12);
    check("pr_code", key_code, 4'h2);
    check("pr_dgt1", dgt1, 4'h2);
    release_all();
    tick();
    wait_release(m);
    check("pr_released", key_held, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
